// File: rtl/spi_flash_responder_if.sv
// Flash pin and byte-memory port bundle for spi_flash_responder.
// slave = the responder; master = the SPI initiator plus the memory that answers mem_rd.
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  flash_sck;
  logic                  flash_cs_n;
  logic                  flash_mosi;
  logic                  flash_miso;
  logic                  flash_miso_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [7:0]            mem_data;

  modport slave (
    input  flash_sck, flash_cs_n, flash_mosi, mem_data,
    output flash_miso, flash_miso_oe, mem_addr, mem_rd
  );

  modport master (
    output flash_sck, flash_cs_n, flash_mosi, mem_data,
    input  flash_miso, flash_miso_oe, mem_addr, mem_rd
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder (READ 0x03, JEDEC ID 0x9F) with oversampled pins.
// Define FAST_READ_EN to also accept FAST READ 0x0B (8 dummy clocks before data).
module spi_flash_responder #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  spi_flash_responder_if.slave    bus,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA_MEM, S_DATA_ID, S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, vld_q;
  logic                   sck_prev_q;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [23:0]            sh_q, sh_d;
  logic [23:0]            addr_q, addr_d;
  logic [23:0]            out_q, out_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   rd_dly_q;
  logic                   fast_q, fast_d;
  logic                   armed_q, armed_d;
  logic                   busy_q;

  logic sck_s, cs_s, mosi_s, sync_valid, cs_active, sck_rise, sck_fall;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sync_valid = vld_q[SYNC_STAGES-1];
  assign cs_active  = sync_valid & ~cs_s;
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;

  assign bus.flash_miso    = miso_q;
  assign bus.flash_miso_oe = oe_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_rd        = mem_rd_q;
  assign busy              = busy_q;

  // CS chain resets to "deasserted"; vld_q masks those reset values so that a
  // transaction only starts after CS is genuinely seen high and then low.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      out_q       <= '1;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_dly_q    <= 1'b0;
      fast_q      <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.flash_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.flash_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.flash_mosi};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rd_dly_q    <= mem_rd_q;
      fast_q      <= fast_d;
      armed_q     <= armed_d;
      busy_q      <= cs_active;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    out_d      = out_q;
    miso_d     = miso_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    fast_d     = fast_q;
    armed_d    = armed_q | (sync_valid & cs_s);

    // Memory data lands one cycle after the strobe; SCK is slow enough that
    // this never coincides with a falling edge.
    if (rd_dly_q) out_d = {bus.mem_data, 16'hFFFF};

    if (!cs_active) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d = S_CMD;
            cnt_d   = '0;
            fast_d  = 1'b0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sh_d  = {sh_q[22:0], mosi_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              unique case (sh_d[7:0])
                8'h03: state_d = S_ADDR;
                8'h9F: begin
                  out_d   = JEDEC_ID;
                  state_d = S_DATA_ID;
                end
`ifdef FAST_READ_EN
                8'h0B: begin
                  fast_d  = 1'b1;
                  state_d = S_ADDR;
                end
`endif
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sh_d  = {sh_q[22:0], mosi_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d      = '0;
              addr_d     = sh_d;
              mem_rd_d   = 1'b1;
              mem_addr_d = sh_d[ADDR_WIDTH-1:0];
              state_d    = fast_q ? S_DUMMY : S_DATA_MEM;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d   = '0;
              state_d = S_DATA_MEM;
            end
          end
        end
        S_DATA_MEM: begin
          if (sck_fall) begin
            miso_d = out_q[23];
            out_d  = {out_q[22:0], 1'b1};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d      = '0;
              addr_d     = addr_q + 24'd1;
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_d[ADDR_WIDTH-1:0];
            end
          end
        end
        S_DATA_ID: begin
          // Shifting in ones makes the bytes after the ID read back as 0xFF.
          if (sck_fall) begin
            miso_d = out_q[23];
            out_d  = {out_q[22:0], 1'b1};
          end
        end
        default: ;
      endcase
    end

    oe_d = cs_active & ((state_d == S_DATA_MEM) || (state_d == S_DATA_ID));
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 flash responder: the device end of the flash bus that the bifrost core drives as initiator.
- Decodes READ (0x03) and JEDEC ID (0x9F) and streams bytes back on flash_miso from a synchronous byte memory port.
- Used as a synthesizable flash stand-in for boot-path testbenches and as an on-board SPI target; all logic runs on the system clock, with SPI pins oversampled.

Parameters:
- ADDR_WIDTH, 16, memory port address width; the low ADDR_WIDTH bits of the 24-bit flash address are used.
- JEDEC_ID, 24'hEF4016, 3 bytes returned MSB-first by command 0x9F.
- SYNC_STAGES, 2, synchronizer depth on flash_sck, flash_cs_n and flash_mosi (min 2).

Ports:
- clock  input  1  system clock, rising edge; flash_sck <= clock/8.
- reset  input  1  synchronous, active-high.
- flash_sck  input  1  SPI clock from initiator, idle low.
- flash_cs_n  input  1  chip select, active low.
- flash_mosi  input  1  initiator-to-responder data.
- flash_miso  output  1  responder-to-initiator data; valid only while flash_miso_oe=1.
- flash_miso_oe  output  1  pad output enable; 1 only in the DATA state with CS asserted.
- mem_addr  output  ADDR_WIDTH  byte address to memory.
- mem_rd  output  1  one-cycle read strobe; mem_data is valid on the cycle after the strobe.
- mem_data  input  8  memory read data.
- busy  output  1  high while CS is asserted (synchronized).

Behaviour:
- Reset values: flash_miso=1, flash_miso_oe=0, mem_addr=0, mem_rd=0, busy=0, state=IDLE, shift counters=0.
- Synchronizers: each input passes through SYNC_STAGES flops. Rising and falling edges of SCK are detected on the synchronized signal. Input-to-action latency is SYNC_STAGES+1 clocks.
- Mode 0 timing: sample flash_mosi on SCK rise; update flash_miso on SCK fall. All data is MSB first.
- CS deassert (synchronized high) from any state: next clock go to IDLE, flash_miso_oe=0, flash_miso=1, bit counter cleared. Any partial byte is discarded.
- IDLE: on CS assert go to CMD with bit count 0.
- CMD: shift 8 bits. On the 8th rise:
  - 0x03 -> ADDR.
  - 0x9F -> load JEDEC_ID into the output shifter, then DATA(ID).
  - anything else -> IGNORE.
- ADDR: shift 24 bits. On the 24th rise, latch addr[23:0], pulse mem_rd with mem_addr=addr[ADDR_WIDTH-1:0], then DATA(MEM).
- DATA(MEM):
  - Load the output shifter with mem_data on the cycle after mem_rd.
  - The first SCK fall after entering DATA drives bit 7; each subsequent fall shifts out the next bit.
  - After the 8th bit of a byte is driven, addr increments and a mem_rd is issued so the next byte is ready before the following fall.
  - Address wraps 24'hFFFFFF -> 0. mem_addr wraps identically in its low bits.
- DATA(ID): shift out the 24 ID bits. Further falls drive 0xFF bytes (miso=1).
- IGNORE: flash_miso_oe=0. Wait for CS deassert.
- Simultaneous SCK edge and CS deassert in the same cycle: CS deassert wins and the edge is ignored.
- SCK edges while CS is deasserted are ignored.
- Reset mid-transfer: all state returns to reset values on the next clock regardless of CS. A new transaction begins only after CS has been observed high then low again.

Optional Feature:
- Macro FAST_READ_EN. When defined, command 0x0B (FAST READ) is accepted: CMD -> ADDR -> DUMMY (8 SCK rises, mosi ignored, miso_oe=0) -> DATA(MEM).
- mem_rd is issued at the end of ADDR, the same as for READ.
- Without the macro, 0x0B goes to IGNORE.

Test Plan:
- Memory preloaded with 0x00..0xFF at addresses 0..255. Send READ 0x03 + addr 0x000010, then 4 bytes -> miso returns 0x10,0x11,0x12,0x13; mem_addr steps 0x10..0x13.
- Send JEDEC 0x9F, then 4 bytes -> returns 0xEF,0x40,0x16,0xFF; miso_oe=1 only during the data phase.
- READ at 24'hFFFFFF for 2 bytes -> returns mem[0xFFFF] then mem[0x0000], confirming 24-bit wrap.
- Unknown command 0x05, then clock 16 more bits -> miso_oe stays 0 and no mem_rd occurs.
- Deassert CS after 12 address bits, then start a new READ at addr 0x20 -> returns mem[0x20] and no stale state is carried over. Reset asserted mid-data-byte -> miso=1, miso_oe=0 on the next clock.
- With FAST_READ_EN: 0x0B + addr 0x000004 + 8 dummy clocks, then 2 bytes -> 0x04,0x05. Without it -> IGNORE, miso_oe=0.
